ahb_default_slave_cfg: RTL and testbench
========================================

Name: ahb_default_slave_cfg

Overview:
- Parametrised AHB-Lite default slave for the bus matrix. It answers every transfer that decodes to an unmapped region.
- Adds to the fixed two-cycle ERROR slave:
  - programmable wait states
  - a selectable OKAY/read-pattern response mode
  - a sticky first-fault log with a saturating fault counter and an interrupt line for the system controller.

Parameters:
- ADDR_WIDTH, 32, width of HADDR and of the captured fault address.
- WAIT_STATES, 0, extra HREADYOUT-low cycles inserted before the response; legal range 0..15.
- RESP_MODE, 0, 0 = two-cycle ERROR response; 1 = single-cycle OKAY, reads return RDATA_PATTERN.
- RDATA_PATTERN, 32'hDEAD_BEEF, HRDATA value returned in OKAY mode; 0 is driven in ERROR mode.
- CNT_WIDTH, 8, width of the saturating fault counter.

Ports:
- HCLK  in  1  AHB clock.
- HRESET  in  1  asynchronous reset, active-high.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  address.
- HTRANS  in  2  transfer type.
- HWRITE  in  1  write flag.
- HREADY  in  1  bus ready (transfer done).
- HREADYOUT  out  1  ready feedback.
- HRESP  out  2  response; 2'b00 OKAY, 2'b01 ERROR.
- HRDATA  out  32  read data.
- err_clr  in  1  single-cycle pulse: clears the fault log and counter.
- err_valid  out  1  sticky: at least one fault logged since the last clear.
- err_addr  out  ADDR_WIDTH  HADDR of the first logged fault.
- err_write  out  1  HWRITE of the first logged fault.
- err_count  out  CNT_WIDTH  number of faults, saturating.
- err_irq  out  1  equal to err_valid, registered.

Behaviour:
- Accept = HSEL & HREADY & HTRANS[1]. IDLE and BUSY are never accepted and always get a zero-wait OKAY.
- Accept is evaluated only in cycles where HREADYOUT=1: states IDLE, ERR2 and OKDONE.
- FSM states: IDLE, WAIT, ERR1, ERR2, OKDONE.
- IDLE: HREADYOUT=1, HRESP=OKAY.
  - On accept with WAIT_STATES>0: load wcnt=WAIT_STATES-1 and go to WAIT.
  - On accept with WAIT_STATES=0: go to ERR1 (RESP_MODE=0) or OKDONE (RESP_MODE=1).
- WAIT: HREADYOUT=0, HRESP=OKAY. Decrement wcnt; when wcnt==0, go to ERR1 or OKDONE.
- ERR1: HREADYOUT=0, HRESP=ERROR. Go to ERR2.
- ERR2: HREADYOUT=1, HRESP=ERROR.
  - An accept in this cycle starts a new response (to WAIT, or to ERR1/OKDONE).
  - Otherwise go to IDLE.
- OKDONE: HREADYOUT=1, HRESP=OKAY. HRDATA=RDATA_PATTERN if the captured HWRITE was 0, else 0. Same accept handling as ERR2.
- Data-phase length from the cycle after the address phase:
  - WAIT_STATES+2 cycles in ERROR mode.
  - WAIT_STATES+1 cycles in OKAY mode.
  - Back-to-back accepted transfers are fully pipelined, with no idle cycle in between.
- HRESP, HREADYOUT and HRDATA are registered outputs, driven directly from state and a data register. There is no combinational path from inputs.
- Fault logging happens on every accept, in both modes:
  - If err_valid=0: capture HADDR into err_addr, HWRITE into err_write, and set err_valid.
  - If err_valid=1: err_addr and err_write hold (first-fault sticky).
  - err_count increments by 1 and saturates at all-ones with no wrap.
- err_clr:
  - Clears err_valid and sets err_count=0.
  - err_clr together with an accept in the same cycle: the accept wins. The new fault is captured, err_valid=1, err_count=1.
- err_irq = err_valid delayed one cycle.
- Reset (HRESET=1, asynchronous, at any time including mid-response):
  - state IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0.
  - err_valid=0, err_addr=0, err_write=0, err_count=0, err_irq=0, wcnt=0.
  - Any in-flight response is abandoned.
- WAIT_STATES outside 0..15 and RESP_MODE not 0/1 are elaboration errors.

Decomposition:
- Package ahb_default_slave_pkg holds:
  - HRESP encodings RSP_OKAY=2'b00, RSP_ERROR=2'b01.
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - The FSM state enumeration.
- One sub-module, ahb_fault_log, implements the capture registers, the saturating counter, the err_clr priority and err_irq. The response FSM stays at top level.

Test Plan:
- ERROR mode, WAIT_STATES=0: one NONSEQ read to 0x4000_1000.
  - Expect one cycle HREADYOUT=0/HRESP=01, then one cycle HREADYOUT=1/HRESP=01.
  - Expect err_addr=0x4000_1000, err_write=0, err_count=1, err_irq high one cycle after err_valid.
- WAIT_STATES=3, ERROR mode: one NONSEQ write.
  - Expect HREADYOUT low for 3 cycles with HRESP=00, then the ERR1 and ERR2 cycles (5 data-phase cycles total).
  - Expect err_write=1.
- RESP_MODE=1, WAIT_STATES=0: read, then back-to-back write.
  - Read returns HRDATA=0xDEADBEEF and HRESP=00 in 1 cycle.
  - Write returns HRDATA=0. No idle cycle between the two responses.
  - Expect err_count=2.
- Pipelined faults and clear:
  - Three consecutive NONSEQ transfers to A, B, C: err_addr stays A, err_count=3.
  - err_clr asserted in the same cycle as the accept of D: err_addr=D, err_count=1.
- Saturation with CNT_WIDTH=2: five faults -> err_count=3 and stays 3.
- HTRANS=IDLE/BUSY with HSEL=1 -> HREADYOUT stays 1, HRESP=00, log unchanged.
- HRESET pulsed during the ERR1 cycle -> outputs return to IDLE values immediately, log cleared.
- After reset deassertion, the next accepted transfer gets a full-length response.

Source files
------------

// File: rtl/ahb_default_slave_pkg.sv
// rtl/ahb_default_slave_pkg.sv - shared encodings and FSM states for the AHB default slave
package ahb_default_slave_pkg;

  localparam logic [1:0] RSP_OKAY  = 2'b00;
  localparam logic [1:0] RSP_ERROR = 2'b01;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2,
    ST_OKDONE
  } state_t;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are answered OKAY without logging.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_fault_log.sv
// rtl/ahb_fault_log.sv - sticky first-fault capture, saturating fault counter and interrupt
module ahb_fault_log #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write,
  input  logic                  clr,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_write,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_irq
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // A clear in the same cycle as a new fault makes that fault the "first" one.
  logic capture;
  assign capture = accept & (clr | ~err_valid);

  // Capture address and direction of the first fault since the last clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr  <= '0;
      err_write <= 1'b0;
    end else if (capture) begin
      err_addr  <= addr;
      err_write <= write;
    end
  end

  // Sticky valid flag; a new fault wins over a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid <= 1'b0;
    end else if (accept) begin
      err_valid <= 1'b1;
    end else if (clr) begin
      err_valid <= 1'b0;
    end
  end

  // Saturating fault counter; clear plus fault restarts the count at one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (accept && clr) begin
      err_count <= CNT_WIDTH'(1);
    end else if (accept) begin
      if (err_count != CNT_MAX) begin
        err_count <= err_count + CNT_WIDTH'(1);
      end
    end else if (clr) begin
      err_count <= '0;
    end
  end

  // Interrupt follows the valid flag one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_irq <= 1'b0;
    end else begin
      err_irq <= err_valid;
    end
  end

endmodule

// File: rtl/ahb_default_slave_cfg.sv
// rtl/ahb_default_slave_cfg.sv - configurable AHB-Lite default slave with wait states and fault log
module ahb_default_slave_cfg #(
  parameter int              ADDR_WIDTH    = 32,
  parameter int              WAIT_STATES   = 0,
  parameter int              RESP_MODE     = 0,
  parameter logic [31:0]     RDATA_PATTERN = 32'hDEAD_BEEF,
  parameter int              CNT_WIDTH     = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [31:0]           HRDATA,
  input  logic                  err_clr,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_write,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_irq
);

  import ahb_default_slave_pkg::*;

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("ahb_default_slave_cfg: WAIT_STATES must be in 0..15");
    end
    if (RESP_MODE != 0 && RESP_MODE != 1) begin : g_bad_resp_mode
      $error("ahb_default_slave_cfg: RESP_MODE must be 0 or 1");
    end
  endgenerate

  // The wait counter counts down to zero, so it is loaded one short of the wait count.
  localparam logic [3:0] WCNT_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam state_t     RESP_STATE  = (RESP_MODE == 1) ? ST_OKDONE : ST_ERR1;
  localparam state_t     START_STATE = (WAIT_STATES > 0) ? ST_WAIT : RESP_STATE;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wcnt;
  logic [31:0] rdata_q;
  logic        ready_state;
  logic        accept;

  // A new address phase can only complete while this slave is driving HREADYOUT high.
  assign ready_state = (state == ST_IDLE) || (state == ST_ERR2) || (state == ST_OKDONE);
  assign accept      = HSEL & HREADY & is_active(HTRANS) & ready_state;

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Wait-state counter and read-data register, loaded at the address phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wcnt    <= 4'd0;
      rdata_q <= 32'd0;
    end else if (accept) begin
      wcnt    <= WCNT_LOAD;
      rdata_q <= HWRITE ? 32'd0 : RDATA_PATTERN;
    end else if (state == ST_WAIT && wcnt != 4'd0) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  // Next-state logic; accept from a ready state pipelines straight into the next response
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_ERR2, ST_OKDONE: begin
        state_next = accept ? START_STATE : ST_IDLE;
      end
      ST_WAIT: begin
        if (wcnt == 4'd0) begin
          state_next = RESP_STATE;
        end
      end
      ST_ERR1: begin
        state_next = ST_ERR2;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Bus outputs decoded from the state register only
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = RSP_OKAY;
    HRDATA    = 32'd0;
    case (state)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = RSP_ERROR;
      end
      ST_ERR2: begin
        HRESP = RSP_ERROR;
      end
      ST_OKDONE: begin
        HRDATA = rdata_q;
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

  ahb_fault_log #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_fault_log (
    .clk       (HCLK),
    .rst       (HRESET),
    .accept    (accept),
    .addr      (HADDR),
    .write     (HWRITE),
    .clr       (err_clr),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .err_write (err_write),
    .err_count (err_count),
    .err_irq   (err_irq)
  );

endmodule

// File: tb/tb_ahb_default_slave_cfg.sv
// tb/tb_ahb_default_slave_cfg.sv - scoreboard bench for the configurable AHB default slave
module tb_ahb_default_slave_cfg;
  import ahb_default_slave_pkg::*;

  typedef struct packed {
    logic        ready;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [7:0]  count;
    logic [31:0] addr;
  } log_t;

  localparam rsp_t R_IDLE = '{ready: 1'b1, resp: 2'b00, rdata: 32'h0};
  localparam rsp_t R_WAIT = '{ready: 1'b0, resp: 2'b00, rdata: 32'h0};
  localparam rsp_t R_ERR1 = '{ready: 1'b0, resp: 2'b01, rdata: 32'h0};
  localparam rsp_t R_ERR2 = '{ready: 1'b1, resp: 2'b01, rdata: 32'h0};

  logic        clk = 1'b0;
  logic        hreset;
  logic [3:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic        err_clr;

  logic        ro  [4];
  logic [1:0]  rs  [4];
  logic [31:0] rd  [4];
  logic        ev  [4];
  logic [31:0] ea  [4];
  logic        ew  [4];
  logic [7:0]  ec  [4];
  logic        irq [4];
  logic [1:0]  ec_sat;

  int   sel;
  int   n_checks;
  int   n_fail;
  rsp_t exp_q[$];
  log_t model [4];
  rsp_t obs_rsp;
  log_t obs_log;
  logic obs_irq;
  rsp_t e;

  always #5 clk = ~clk;

  assign ec[3] = {6'd0, ec_sat};

  always_comb begin
    obs_rsp = {ro[sel], rs[sel], rd[sel]};
    obs_log = {ev[sel], ew[sel], ec[sel], ea[sel]};
    obs_irq = irq[sel];
  end

  ahb_default_slave_cfg #(.ADDR_WIDTH(32), .WAIT_STATES(0), .RESP_MODE(0),
    .RDATA_PATTERN(32'hDEAD_BEEF), .CNT_WIDTH(8)) dut_err0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HREADY(ro[0]), .HREADYOUT(ro[0]), .HRESP(rs[0]), .HRDATA(rd[0]),
    .err_clr(err_clr), .err_valid(ev[0]), .err_addr(ea[0]), .err_write(ew[0]),
    .err_count(ec[0]), .err_irq(irq[0]));

  ahb_default_slave_cfg #(.ADDR_WIDTH(32), .WAIT_STATES(3), .RESP_MODE(0),
    .RDATA_PATTERN(32'hDEAD_BEEF), .CNT_WIDTH(8)) dut_err3 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HREADY(ro[1]), .HREADYOUT(ro[1]), .HRESP(rs[1]), .HRDATA(rd[1]),
    .err_clr(err_clr), .err_valid(ev[1]), .err_addr(ea[1]), .err_write(ew[1]),
    .err_count(ec[1]), .err_irq(irq[1]));

  ahb_default_slave_cfg #(.ADDR_WIDTH(32), .WAIT_STATES(0), .RESP_MODE(1),
    .RDATA_PATTERN(32'hDEAD_BEEF), .CNT_WIDTH(8)) dut_okay (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HREADY(ro[2]), .HREADYOUT(ro[2]), .HRESP(rs[2]), .HRDATA(rd[2]),
    .err_clr(err_clr), .err_valid(ev[2]), .err_addr(ea[2]), .err_write(ew[2]),
    .err_count(ec[2]), .err_irq(irq[2]));

  ahb_default_slave_cfg #(.ADDR_WIDTH(32), .WAIT_STATES(0), .RESP_MODE(0),
    .RDATA_PATTERN(32'hDEAD_BEEF), .CNT_WIDTH(2)) dut_sat (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[3]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HREADY(ro[3]), .HREADYOUT(ro[3]), .HRESP(rs[3]), .HRDATA(rd[3]),
    .err_clr(err_clr), .err_valid(ev[3]), .err_addr(ea[3]), .err_write(ew[3]),
    .err_count(ec_sat), .err_irq(irq[3]));

  // Reference behaviour of the fault log for one accepted transfer.
  function automatic log_t model_accept(input log_t m, input logic [31:0] a, input logic w,
                                        input logic clr, input logic [7:0] maxc);
    log_t r = m;
    if (clr || !m.valid) begin
      r.addr  = a;
      r.write = w;
    end
    if (clr) r.count = 8'd1;
    else if (m.count != maxc) r.count = m.count + 8'd1;
    r.valid = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] max_count(input int s);
    return (s == 3) ? 8'd3 : 8'd255;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_bus(input logic [31:0] a, input logic w, input logic [1:0] t);
    hsel      = 4'b0000;
    hsel[sel] = 1'b1;
    haddr     = a;
    hwrite    = w;
    htrans    = t;
  endtask

  task automatic bus_idle();
    hsel   = 4'b0000;
    haddr  = 32'h0;
    hwrite = 1'b0;
    htrans = HTRANS_IDLE;
  endtask

  task automatic pop_exp(output rsp_t r);
    if (exp_q.size() == 0) r = 'x;
    else r = exp_q.pop_front();
  endtask

  task automatic clear_models();
    for (int k = 0; k < 4; k++) begin
      model[k].valid = 1'b0;
      model[k].count = 8'd0;
    end
  endtask

  task automatic test_reset();
    hreset  = 1'b1;
    err_clr = 1'b0;
    bus_idle();
    for (int k = 0; k < 4; k++) model[k] = '0;
    step();
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #1;
      n_checks++;
      if (obs_rsp !== R_IDLE) begin
        n_fail++;
        $display("FAIL reset_rsp dut%0d: got %h expected %h", k, obs_rsp, R_IDLE);
      end
      n_checks++;
      if (obs_log !== model[k]) begin
        n_fail++;
        $display("FAIL reset_log dut%0d: got %h expected %h", k, obs_log, model[k]);
      end
      n_checks++;
      if (obs_irq !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_irq dut%0d: got %b expected 0", k, obs_irq);
      end
    end
    step();
    hreset = 1'b0;
    step();
  endtask

  task automatic test_error_ws0();
    sel = 0;
    set_bus(32'h4000_1000, 1'b0, HTRANS_NONSEQ);
    model[0] = model_accept(model[0], 32'h4000_1000, 1'b0, 1'b0, max_count(0));
    exp_q.push_back(R_ERR1);
    exp_q.push_back(R_ERR2);
    exp_q.push_back(R_IDLE);
    step();
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      pop_exp(e);
      n_checks++;
      if (obs_rsp !== e) begin
        n_fail++;
        $display("FAIL err_ws0_rsp cycle%0d: got %h expected %h", i, obs_rsp, e);
      end
      if (i < 2) begin
        n_checks++;
        if (obs_irq !== (i == 1)) begin
          n_fail++;
          $display("FAIL err_ws0_irq cycle%0d: got %b expected %b", i, obs_irq, (i == 1));
        end
      end
      step();
    end
    n_checks++;
    if (obs_log !== model[0]) begin
      n_fail++;
      $display("FAIL err_ws0_log: got %h expected %h", obs_log, model[0]);
    end
  endtask

  task automatic test_wait_states();
    sel = 1;
    set_bus(32'h4000_2000, 1'b1, HTRANS_NONSEQ);
    model[1] = model_accept(model[1], 32'h4000_2000, 1'b1, 1'b0, max_count(1));
    for (int i = 0; i < 3; i++) exp_q.push_back(R_WAIT);
    exp_q.push_back(R_ERR1);
    exp_q.push_back(R_ERR2);
    exp_q.push_back(R_IDLE);
    step();
    bus_idle();
    for (int i = 0; i < 6; i++) begin
      pop_exp(e);
      n_checks++;
      if (obs_rsp !== e) begin
        n_fail++;
        $display("FAIL wait3_rsp cycle%0d: got %h expected %h", i, obs_rsp, e);
      end
      step();
    end
    n_checks++;
    if (obs_log !== model[1]) begin
      n_fail++;
      $display("FAIL wait3_log: got %h expected %h", obs_log, model[1]);
    end
  endtask

  task automatic test_okay_back_to_back();
    sel = 2;
    set_bus(32'h5000_0000, 1'b0, HTRANS_NONSEQ);
    model[2] = model_accept(model[2], 32'h5000_0000, 1'b0, 1'b0, max_count(2));
    exp_q.push_back('{ready: 1'b1, resp: 2'b00, rdata: 32'hDEAD_BEEF});
    step();
    set_bus(32'h5000_0004, 1'b1, HTRANS_NONSEQ);
    model[2] = model_accept(model[2], 32'h5000_0004, 1'b1, 1'b0, max_count(2));
    exp_q.push_back(R_IDLE);
    exp_q.push_back(R_IDLE);
    for (int i = 0; i < 3; i++) begin
      pop_exp(e);
      n_checks++;
      if (obs_rsp !== e) begin
        n_fail++;
        $display("FAIL okay_rsp cycle%0d: got %h expected %h", i, obs_rsp, e);
      end
      step();
      bus_idle();
    end
    n_checks++;
    if (obs_log !== model[2]) begin
      n_fail++;
      $display("FAIL okay_log: got %h expected %h", obs_log, model[2]);
    end
  endtask

  // Back-to-back ERROR-mode faults on the selected slave, optional clear on one accept.
  task automatic test_back_to_back(input int n, input logic [31:0] base, input int clr_idx);
    logic [31:0] a;
    a = base;
    set_bus(a, 1'b0, HTRANS_NONSEQ);
    err_clr = (clr_idx == 0);
    if (err_clr) clear_models();
    model[sel] = model_accept(model[sel], a, 1'b0, err_clr, max_count(sel));
    exp_q.push_back(R_ERR1);
    exp_q.push_back(R_ERR2);
    for (int i = 0; i < n; i++) begin
      step();
      err_clr = 1'b0;
      if (i + 1 < n) set_bus(base + 32'(4 * (i + 1)), 1'(i % 2), HTRANS_NONSEQ);
      else bus_idle();
      pop_exp(e);
      n_checks++;
      if (obs_rsp !== e) begin
        n_fail++;
        $display("FAIL b2b_rsp xfer%0d err1: got %h expected %h", i, obs_rsp, e);
      end
      n_checks++;
      if (obs_log !== model[sel]) begin
        n_fail++;
        $display("FAIL b2b_log xfer%0d: got %h expected %h", i, obs_log, model[sel]);
      end
      step();
      pop_exp(e);
      n_checks++;
      if (obs_rsp !== e) begin
        n_fail++;
        $display("FAIL b2b_rsp xfer%0d err2: got %h expected %h", i, obs_rsp, e);
      end
      if (i + 1 < n) begin
        err_clr = (clr_idx == i + 1);
        if (err_clr) clear_models();
        model[sel] = model_accept(model[sel], haddr, hwrite, err_clr, max_count(sel));
        exp_q.push_back(R_ERR1);
        exp_q.push_back(R_ERR2);
      end
    end
    step();
  endtask

  task automatic test_clear_then_faults();
    sel = 0;
    err_clr = 1'b1;
    clear_models();
    step();
    err_clr = 1'b0;
    n_checks++;
    if (obs_log.valid !== 1'b0 || obs_log.count !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_only: got valid=%b count=%0d expected valid=0 count=0",
               obs_log.valid, obs_log.count);
    end
    test_back_to_back(4, 32'h6000_0000, 3);
    n_checks++;
    if (obs_log.addr !== 32'h6000_000C || obs_log.count !== 8'd1) begin
      n_fail++;
      $display("FAIL clr_with_accept: got addr=%h count=%0d expected addr=6000000c count=1",
               obs_log.addr, obs_log.count);
    end
  endtask

  task automatic test_saturation();
    sel = 3;
    test_back_to_back(5, 32'h7000_0000, -1);
    n_checks++;
    if (obs_log.count !== 8'd3 || obs_log.addr !== 32'h7000_0000) begin
      n_fail++;
      $display("FAIL saturation: got count=%0d addr=%h expected count=3 addr=70000000",
               obs_log.count, obs_log.addr);
    end
  endtask

  task automatic test_idle_busy();
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      set_bus(32'h4000_F000, 1'b1, (i < 2) ? HTRANS_IDLE : HTRANS_BUSY);
      exp_q.push_back(R_IDLE);
      step();
      pop_exp(e);
      n_checks++;
      if (obs_rsp !== e) begin
        n_fail++;
        $display("FAIL idle_busy_rsp cycle%0d: got %h expected %h", i, obs_rsp, e);
      end
      n_checks++;
      if (obs_log !== model[0]) begin
        n_fail++;
        $display("FAIL idle_busy_log cycle%0d: got %h expected %h", i, obs_log, model[0]);
      end
    end
    bus_idle();
    step();
  endtask

  task automatic test_reset_mid_response();
    sel = 0;
    set_bus(32'h4000_3000, 1'b0, HTRANS_NONSEQ);
    model[0] = model_accept(model[0], 32'h4000_3000, 1'b0, 1'b0, max_count(0));
    exp_q.push_back(R_ERR1);
    step();
    bus_idle();
    pop_exp(e);
    n_checks++;
    if (obs_rsp !== e) begin
      n_fail++;
      $display("FAIL rst_mid_err1: got %h expected %h", obs_rsp, e);
    end
    #2;
    hreset = 1'b1;
    for (int k = 0; k < 4; k++) model[k] = '0;
    #1;
    n_checks++;
    if (obs_rsp !== R_IDLE) begin
      n_fail++;
      $display("FAIL rst_mid_rsp: got %h expected %h", obs_rsp, R_IDLE);
    end
    n_checks++;
    if (obs_log !== model[0] || obs_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_log: got %h irq=%b expected %h irq=0", obs_log, obs_irq, model[0]);
    end
    step();
    hreset = 1'b0;
    step();
    set_bus(32'h4000_4000, 1'b1, HTRANS_NONSEQ);
    model[0] = model_accept(model[0], 32'h4000_4000, 1'b1, 1'b0, max_count(0));
    exp_q.push_back(R_ERR1);
    exp_q.push_back(R_ERR2);
    exp_q.push_back(R_IDLE);
    step();
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      pop_exp(e);
      n_checks++;
      if (obs_rsp !== e) begin
        n_fail++;
        $display("FAIL after_rst_rsp cycle%0d: got %h expected %h", i, obs_rsp, e);
      end
      if (i == 0) begin
        n_checks++;
        if (obs_log !== model[0]) begin
          n_fail++;
          $display("FAIL after_rst_log: got %h expected %h", obs_log, model[0]);
        end
      end
      step();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sel      = 0;
    test_reset();
    test_error_ws0();
    test_wait_states();
    test_okay_back_to_back();
    test_clear_then_faults();
    test_saturation();
    test_idle_busy();
    test_reset_mid_response();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
